// File: rtl/apb_master_arbiter.sv
// Round-robin APB master: arbitrates NO_REQ command ports onto a single APB
// slave, runs the SETUP/ACCESS handshake with wait-state timeout, and returns
// the response to the winning requester.
module apb_master_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned NO_REQ     = 2,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                         PCLK,
   input  logic                         PRESET,
   input  logic [NO_REQ-1:0]            req_valid,
   input  logic [NO_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NO_REQ-1:0]            req_write,
   input  logic [NO_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NO_REQ-1:0]            req_ready,
   output logic [NO_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]        rsp_rdata,
   output logic                         rsp_err,
   output logic [ADDR_WIDTH-1:0]        PADDR,
   output logic                         PWRITE,
   output logic [DATA_WIDTH-1:0]        PWDATA,
   output logic                         PSELx,
   output logic                         PENABLE,
   input  logic                         PREADY,
   input  logic [DATA_WIDTH-1:0]        PRDATA,
   input  logic                         PSLVERR
);

   localparam int unsigned IDX_W = (NO_REQ > 1) ? $clog2(NO_REQ) : 1;
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit          TO_EN = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        last_grant_q, last_grant_d;
   logic [IDX_W-1:0]        grant_q, grant_d;
   logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
   logic                    pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
   logic                    psel_q, psel_d;
   logic                    penable_q, penable_d;
   logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
   logic [NO_REQ-1:0]       rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                    rsp_err_q, rsp_err_d;

   logic                    win_found_c;
   logic [IDX_W-1:0]        win_idx_c;
   int unsigned             rr_idx;
   logic [ADDR_WIDTH-1:0]   sel_addr_c;
   logic                    sel_write_c;
   logic [DATA_WIDTH-1:0]   sel_wdata_c;
   logic                    timeout_hit_c;

   // Round-robin search: first valid requester at or after last_grant+1.
   always_comb begin
      win_found_c = 1'b0;
      win_idx_c   = '0;
      rr_idx      = 0;
      for (int k = 0; k < int'(NO_REQ); k++) begin
         rr_idx = (32'(last_grant_q) + 32'(k) + 32'd1) % NO_REQ;
         if (!win_found_c && req_valid[IDX_W'(rr_idx)]) begin
            win_found_c = 1'b1;
            win_idx_c   = IDX_W'(rr_idx);
         end
      end
   end

   // Select the winning requester's command fields from the flattened buses.
   always_comb begin
      sel_addr_c  = '0;
      sel_write_c = 1'b0;
      sel_wdata_c = '0;
      for (int i = 0; i < int'(NO_REQ); i++) begin
         if (win_idx_c == IDX_W'(i)) begin
            sel_addr_c  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_write_c = req_write[i];
            sel_wdata_c = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign timeout_hit_c = TO_EN && (wait_cnt_q == TO_LAST);

   // Transfer FSM: next state, command latch, response and APB strobes.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      paddr_d      = paddr_q;
      pwrite_d     = pwrite_q;
      pwdata_d     = pwdata_q;
      wait_cnt_d   = wait_cnt_q;
      rsp_valid_d  = '0;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_err_d    = rsp_err_q;
      req_ready    = '0;

      unique case (state_q)
         S_IDLE: begin
            if (win_found_c) begin
               req_ready[win_idx_c] = 1'b1;
               last_grant_d         = win_idx_c;
               grant_d              = win_idx_c;
               paddr_d              = sel_addr_c;
               pwrite_d             = sel_write_c;
               pwdata_d             = sel_wdata_c;
               state_d              = S_SETUP;
            end
         end
         S_SETUP: begin
            wait_cnt_d = '0;
            state_d    = S_ACCESS;
         end
         S_ACCESS: begin
            if (PREADY) begin
               rsp_valid_d[grant_q] = 1'b1;
               rsp_rdata_d          = pwrite_q ? '0 : PRDATA;
               rsp_err_d            = PSLVERR;
               state_d              = S_IDLE;
            end else if (timeout_hit_c) begin
               rsp_valid_d[grant_q] = 1'b1;
               rsp_rdata_d          = '0;
               rsp_err_d            = 1'b1;
               state_d              = S_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      psel_d    = (state_d != S_IDLE);
      penable_d = (state_d == S_ACCESS);
   end

   // State and datapath registers; reset aborts any transfer in flight.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q      <= S_IDLE;
         last_grant_q <= IDX_W'(NO_REQ - 1);
         grant_q      <= '0;
         paddr_q      <= '0;
         pwrite_q     <= 1'b0;
         pwdata_q     <= '0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         wait_cnt_q   <= '0;
         rsp_valid_q  <= '0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         paddr_q      <= paddr_d;
         pwrite_q     <= pwrite_d;
         pwdata_q     <= pwdata_d;
         psel_q       <= psel_d;
         penable_q    <= penable_d;
         wait_cnt_q   <= wait_cnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign PADDR     = paddr_q;
   assign PWRITE    = pwrite_q;
   assign PWDATA    = pwdata_q;
   assign PSELx     = psel_q;
   assign PENABLE   = penable_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Round-robin APB master that shares one APB slave port (PSELx/PENABLE handshake) between NO_REQ internal requesters. Each requester hands over one address/data/direction command. The block arbitrates, runs the APB SETUP/ACCESS sequence with wait-state and timeout handling, and returns read data and error status to the winner. It sits directly in front of the APB slave under test and drives its master-side inputs.

## Interface
- DATA_WIDTH, 32, APB data width (multiple of 8).
- ADDR_WIDTH, 32, APB address width.
- NO_REQ, 2, number of requesters (2..8).
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before forced error. 0 disables the timeout.
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- req_valid  in  NO_REQ  per-requester command pending.
- req_addr  in  NO_REQ*ADDR_WIDTH  flattened addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_write  in  NO_REQ  1 = write, 0 = read.
- req_wdata  in  NO_REQ*DATA_WIDTH  flattened write data.
- req_ready  out  NO_REQ  one-hot grant; command accepted on the edge where it is high.
- rsp_valid  out  NO_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data, shared; valid with rsp_valid.
- rsp_err  out  1  error status, valid with rsp_valid.
- PADDR  out  ADDR_WIDTH  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PREADY  in  1  slave ready.
- PRDATA  in  DATA_WIDTH  slave read data.
- PSLVERR  in  1  slave error.

## Operation
- FSM states:
  - IDLE to SETUP when any req_valid is high.
  - SETUP to ACCESS unconditionally.
  - ACCESS to IDLE when PREADY is high, or on timeout.
  - Otherwise ACCESS holds.
- Arbitration (IDLE only):
  - The winner is the first req_valid at or after index (last_grant+1) mod NO_REQ.
  - req_ready[winner] is combinational and high only in that IDLE cycle.
  - At the edge, the block latches the winner's addr/write/wdata and index, and last_grant takes the winner's index.
  - last_grant resets to NO_REQ-1, so requester 0 has first priority.
- APB drive:
  - SETUP: PSELx=1, PENABLE=0.
  - ACCESS: PSELx=1, PENABLE=1.
  - IDLE: both 0.
  - PADDR/PWRITE/PWDATA are registered and stable from SETUP through the end of ACCESS. In IDLE they hold their last values.
- Completion (PREADY=1 in ACCESS): at that edge, rsp_valid[granted] is set for one cycle.
  - Reads: rsp_rdata = PRDATA.
  - Writes: rsp_rdata = 0.
  - rsp_err = PSLVERR in both cases.
- Timeout:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 with PREADY still low, the transfer ends: IDLE, rsp_valid pulse, rsp_err=1, rsp_rdata=0.
  - PREADY=1 on the final cycle takes precedence over timeout (normal completion).
- req_valid dropping after grant has no effect; the latched command completes.
- Requester protocol: hold req_valid until req_ready is seen. Only one transfer is outstanding at a time.

## Timing
- Reset values: state IDLE, last_grant NO_REQ-1. All outputs are 0: req_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PWRITE, PWDATA, PSELx, PENABLE.
- Zero-wait transfer: grant cycle (IDLE), SETUP, ACCESS (PREADY=1). rsp_valid is high in the following cycle, which is IDLE.
- In that IDLE cycle a new grant may occur. Minimum period is 3 cycles per transfer, and the bus is idle for one cycle between transfers.
- Each PREADY-low ACCESS cycle adds one cycle of latency.
- rsp_valid, rsp_rdata and rsp_err are registered. rsp_rdata/rsp_err hold until the next completion.
- Reset asserted mid-transfer: PSELx/PENABLE drop asynchronously and no rsp_valid is issued for the aborted transfer. Arbitration restarts with requester 0 first.

## Test plan
- Single write, zero wait: req 0 write addr 0x10, data 0xDEADBEEF.
  - req_ready[0] high 1 cycle, then SETUP with PADDR=0x10, PWRITE=1.
  - Then ACCESS, then rsp_valid[0]=1 with rsp_err=0, rsp_rdata=0. Total 4 cycles from req_valid to rsp_valid.
- Read with 3 wait states: req 1 reads 0x24; slave returns PRDATA=0x12345678 with PREADY low for 3 cycles.
  - ACCESS lasts 4 cycles; rsp_valid[1] carries rsp_rdata=0x12345678.
- Round-robin fairness: req 0 and req 1 both held valid for 4 transfers.
  - Grant order is 0,1,0,1. Each grant is 3 cycles apart on a zero-wait slave.
- Slave error: PSLVERR=1 with PREADY on a read.
  - rsp_err=1, rsp_rdata=PRDATA; rsp_err returns to 0 on the next clean transfer.
- Timeout with TIMEOUT=16, PREADY held 0:
  - Exactly 16 ACCESS cycles, then IDLE with rsp_err=1, rsp_rdata=0.
  - If PREADY rises on the 16th cycle instead, the transfer completes normally with rsp_err=PSLVERR.
- Reset mid-ACCESS: assert PRESET during wait states.
  - PSELx/PENABLE go 0 immediately and no rsp_valid is issued.
  - After release, with req 1 and req 0 both valid, req 0 is granted first.
